dff_pipe: RTL and testbench

//   Parametrised elastic register pipeline: WIDTH-bit data through DEPTH stages with valid/ready flow control.

---
 rtl/dff_pipe.sv | 81 ++++++++
 tb/tb_dff_pipe.sv | 93 +++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: elastic WIDTH-bit register pipeline of DEPTH stages with valid/ready flow control
// Ports: clk, rst (sync, active-high); upstream in_valid/in_ready/d; downstream out_valid/out_ready/q;
//        flush clears every stage; count = number of valid stages (registered);
//        par_err = parity mismatch on q.
// Build option: define DFF_PIPE_PARITY_EN to carry an even-parity bit with each stage;
//        otherwise par_err is tied to 0 (port list identical in both builds).
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           q,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       par_err
);
  localparam int CW = $clog2(DEPTH+1);
  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be >= 1");
  end
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt;
  logic             w_a;
  // A stage advances if any stage at or after it is empty, or the output drains;
  // accumulating from the tail avoids a self-referencing vector.
  always_comb begin
    w_a = out_ready;
    w_adv = '0;
    w_v_nxt = '0;
    w_cnt = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_a = w_a || !r_v[k];
      w_adv[k] = w_a;
    end
    w_v_nxt[0] = w_adv[0] ? in_valid : r_v[0];
    for (int k = 1; k < DEPTH; k++) w_v_nxt[k] = w_adv[k] ? r_v[k-1] : r_v[k];
    for (int k = 0; k < DEPTH; k++) w_cnt = w_cnt + CW'(w_v_nxt[k]);
  end
  assign in_ready  = w_adv[0] && !flush && !rst;
  assign out_valid = r_v[DEPTH-1];
  assign q         = r_d[DEPTH-1];
  assign count     = r_cnt;
  // Data only moves with a valid word, so q holds its last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_v <= '0;
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= RESET_VAL;
    end else begin
      r_v <= w_v_nxt;
      r_cnt <= w_cnt;
      if (w_adv[0] && in_valid) r_d[0] <= d;
      for (int k = 1; k < DEPTH; k++) if (w_adv[k] && r_v[k-1]) r_d[k] <= r_d[k-1];
    end
  end
`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] r_p;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_p <= '0;
    end else begin
      if (w_adv[0] && in_valid) r_p[0] <= ^d;
      for (int k = 1; k < DEPTH; k++) if (w_adv[k] && r_v[k-1]) r_p[k] <= r_p[k-1];
    end
  end
  assign par_err = r_v[DEPTH-1] && ((^r_d[DEPTH-1]) != r_p[DEPTH-1]);
`else
  assign par_err = 1'b0;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed + random checks of dff_pipe against a word-queue reference model
module tb_dff_pipe;
  localparam int D = 3;
  localparam logic [7:0] RV = 8'hA5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  logic [7:0] d = '0;
  logic in_ready, out_valid, par_err;
  logic [7:0] q;
  logic [1:0] count;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [7:0] data; int pos; bit bad;} ent_t;
  ent_t m[$];
  logic [7:0] exp_q = RV;
  dff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .flush(flush),
    .count(count), .par_err(par_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit m_ovalid();
    return m.size() > 0 && m[0].pos == D - 1;
  endfunction
  // Model: in-flight words kept oldest-first with their stage position; each edge
  // the head may leave, then every word moves up one stage if that slot is free.
  task automatic step(input bit iv, input logic [7:0] id, input bit ord, input bit fl, input bit rs);
    bit rdy;
    int lim;
    in_valid = iv; d = id; out_ready = ord; flush = fl; rst = rs;
    #1;
    rdy = !rs && !fl && (m.size() < D || ord);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (rs || fl) begin
      m.delete();
      exp_q = RV;
    end else begin
      if (ord && m_ovalid()) void'(m.pop_front());
      lim = D;
      foreach (m[i]) begin
        if (m[i].pos + 1 < lim) m[i].pos++;
        lim = m[i].pos;
      end
      if (iv && rdy) m.push_back('{id, 0, 1'b0});
      if (m_ovalid()) exp_q = m[0].data;
    end
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ovalid()});
    chk("q", {24'd0, q}, {24'd0, exp_q});
    chk("count", {30'd0, count}, m.size());
    chk("par_err", {31'd0, par_err}, {31'd0, m_ovalid() && m[0].bad});
  endtask
  initial begin
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h33, 1, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, 8'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
    step(1, 8'h40, 1, 0, 0);
    step(1, 8'h41, 0, 0, 0);
`ifdef DFF_PIPE_PARITY_EN
    dut.r_d[1] = dut.r_d[1] ^ 8'h01;
    m[1].data = m[1].data ^ 8'h01;
    m[1].bad = 1'b1;
`endif
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    step(1, 8'h51, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h52, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h53, 0, 0, 0);
    step(1, 8'hFF, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
